aes_roundtrip_checker: RTL

Parametrised successor to the 128-bit AES encrypt/decrypt driver. Accepts plaintext blocks over a valid/ready handshake and sequences an external AES core through encrypt then decrypt. Checks ciphertext against an optional expected value and checks that the round-trip result equals the plaintext. Reports per-block encrypt/decrypt pass flags, running pass/fail counters and core timeouts; sits between the stimulus source/self-test ROM and the AES core.

---
 rtl/aes_roundtrip_checker.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/aes_roundtrip_checker.sv
// AES round-trip checker: drives an external AES core through encrypt
// then decrypt per block and scores ciphertext and round-trip results.
module aes_roundtrip_checker #(
   parameter int DATA_W  = 128,
   parameter int KEY_W   = 128,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              clear_cnt,
   input  logic [KEY_W-1:0]  key,
   input  logic              pt_valid,
   output logic              pt_ready,
   input  logic [DATA_W-1:0] pt_data,
   input  logic              exp_chk,
   input  logic [DATA_W-1:0] exp_ct,
   output logic              core_start,
   output logic              core_mode,
   output logic [KEY_W-1:0]  core_key,
   output logic [DATA_W-1:0] core_din,
   input  logic              core_done,
   input  logic [DATA_W-1:0] core_dout,
   output logic              e_pass,
   output logic              d_pass,
   output logic              blk_done,
   output logic              timeout_err,
   output logic              busy,
   output logic [CNT_W-1:0]  pass_cnt,
   output logic [CNT_W-1:0]  fail_cnt
);

   localparam int TMR_W = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      IDLE,
      ENC_REQ,
      ENC_WAIT,
      DEC_REQ,
      DEC_WAIT,
      REPORT
   } state_t;

   state_t state;
   state_t state_nx;

   logic [DATA_W-1:0] pt_q;
   logic [DATA_W-1:0] exp_q;
   logic [DATA_W-1:0] ct_q;
   logic [KEY_W-1:0]  key_q;
   logic              chk_q;
   logic              enc_ok;
   logic [TMR_W-1:0]  timer;
   logic              tmr_hit;
   logic              accept;
   logic              blk_ok;

   assign tmr_hit  = (timer == TMR_LAST);
   assign accept   = (state == IDLE) && enable && pt_valid;
   assign blk_ok   = e_pass && d_pass;
   assign core_key = key_q;

   always_comb begin
      state_nx   = state;
      pt_ready   = 1'b0;
      core_start = 1'b0;
      core_mode  = 1'b0;
      core_din   = pt_q;
      blk_done   = 1'b0;
      busy       = 1'b1;
      unique case (state)
         IDLE: begin
            busy     = 1'b0;
            pt_ready = enable;
            if (accept) state_nx = ENC_REQ;
         end
         ENC_REQ: begin
            core_start = 1'b1;
            state_nx   = ENC_WAIT;
         end
         ENC_WAIT: begin
            if (core_done)    state_nx = DEC_REQ;
            else if (tmr_hit) state_nx = REPORT;
         end
         DEC_REQ: begin
            core_start = 1'b1;
            core_mode  = 1'b1;
            core_din   = ct_q;
            state_nx   = DEC_WAIT;
         end
         DEC_WAIT: begin
            core_mode = 1'b1;
            core_din  = ct_q;
            if (core_done || tmr_hit) state_nx = REPORT;
         end
         REPORT: begin
            blk_done = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         pt_q        <= '0;
         exp_q       <= '0;
         ct_q        <= '0;
         key_q       <= '0;
         chk_q       <= 1'b0;
         enc_ok      <= 1'b0;
         timer       <= '0;
         e_pass      <= 1'b0;
         d_pass      <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_nx;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  pt_q  <= pt_data;
                  exp_q <= exp_ct;
                  chk_q <= exp_chk;
                  key_q <= key;
               end
            end
            ENC_REQ, DEC_REQ: timer <= '0;
            ENC_WAIT: begin
               if (core_done) begin
                  ct_q   <= core_dout;
                  enc_ok <= chk_q ? (core_dout == exp_q)
                                  : (core_dout != pt_q);
               end else if (tmr_hit) begin
                  enc_ok      <= 1'b0;
                  e_pass      <= 1'b0;
                  d_pass      <= 1'b0;
                  timeout_err <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            DEC_WAIT: begin
               // flags land on REPORT entry so they line up with blk_done
               if (core_done) begin
                  e_pass      <= enc_ok;
                  d_pass      <= (core_dout == pt_q);
                  timeout_err <= 1'b0;
               end else if (tmr_hit) begin
                  enc_ok      <= 1'b0;
                  e_pass      <= 1'b0;
                  d_pass      <= 1'b0;
                  timeout_err <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pass_cnt <= '0;
         fail_cnt <= '0;
      end else if (clear_cnt) begin
         pass_cnt <= '0;
         fail_cnt <= '0;
      end else if (state == REPORT) begin
         if (blk_ok) begin
            if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
         end else begin
            if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
         end
      end
   end

endmodule
